sram_bus_frontend: RTL
======================

// Module: sram_bus_frontend
// PURPOSE
//  Upstream stage of the FPGA SRAM emulator. Sits between the async SRAM-style pins
//  driven by the Arduino Due and the memory/read-modify-write core.
//  Synchronises the pins into clk, filters glitches and turns each qualified strobe
//  into exactly one valid/ready request.
//  Data tristate lives downstream; this block only observes bus_data_in.
// PARAMETERS
//  ADDR_W      22  bus address width
//  DATA_W      16  bus data width
//  SYNC_STAGES 2   synchroniser flops on every pin (>=2)
//  SETTLE_CYC  2   consecutive synced cycles a strobe must hold before capture (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset, asynchronous, active-high
//  fpga_enable  in   1       async pin; low = block idle, bus ignored
//  bus_ce_n     in   1       async chip enable, active low
//  bus_ce2      in   1       async chip enable 2, active high
//  bus_we_n     in   1       async write strobe, active low
//  bus_oe_n     in   1       async output enable, active low
//  bus_lb_n     in   1       async lower-byte enable, active low
//  bus_addr     in   ADDR_W  async address pins
//  bus_data_in  in   DATA_W  async data pins (input side)
//  req_valid    out  1       request pending to core
//  req_ready    in   1       core accepts request
//  req_write    out  1       1 = write, 0 = read
//  req_lb       out  1       1 = lower byte only (bus_lb_n was low)
//  req_addr     out  ADDR_W  captured address
//  req_wdata    out  DATA_W  captured write data (0 for reads)
//  rd_active    out  1       read access in progress; core may drive data
//  err_overrun  out  1       sticky: strobe dropped while request outstanding
// BEHAVIOUR
//  - Sync: every pin goes through SYNC_STAGES flops. All decisions and captures
//    use the synced copies (_s).
//  - sel = en_s & ~ce_n_s & ce2_s; wr = sel & ~we_n_s; rd = sel & we_n_s & ~oe_n_s.
//    WE# has priority when WE# and OE# are both low.
//  - Reset values: state=IDLE; all outputs 0; sync flops 1 for *_n, 0 otherwise.
//  - FSM IDLE / SETTLE / ISSUE / HOLD:
//    IDLE: wr|rd -> latch type, cnt=1. Go to ISSUE if SETTLE_CYC==1, else SETTLE.
//    SETTLE: type still present -> cnt++. When cnt==SETTLE_CYC -> capture and go
//      to ISSUE. Type lost or changed -> IDLE, no request.
//    Capture: req_addr=addr_s, req_lb=~lb_n_s, req_write=type,
//      req_wdata = write ? data_s : 0. At the same edge req_valid<=1.
//    ISSUE: req_valid and all req_* held stable until req_valid&req_ready.
//      That edge clears req_valid; strobe still present -> HOLD, else IDLE.
//    HOLD: wait until wr|rd both low -> IDLE. One request per strobe assertion.
//  - Latency: req_valid rises SYNC_STAGES+SETTLE_CYC edges after the first edge
//    that samples a qualified strobe (4 at defaults).
//  - Handshake takes at least 1 cycle; req_ready may already be high when
//    req_valid rises.
//  - rd_active = (state==ISSUE|HOLD) & ~req_write & rd.
//  - Overrun: in ISSUE, strobe deasserts then reasserts (synced) before
//    acceptance -> err_overrun<=1 and the second access is dropped.
//    err_overrun is cleared only by rst.
//  - en_s low: any state -> IDLE next edge; req_valid, rd_active <=0, even mid-handshake.
//  - rst asserted mid-operation: all flops return to reset values immediately
//    (async); the pending request is lost.
//  - Address wrap: none. Address is passed through unmodified.
// TESTING
//  1 Write: ce_n=0,ce2=1,we_n=0,addr=0x000010,data=0xABCD, ready=1
//    -> req_valid 4 cycles later with write=1,addr=0x000010,wdata=0xABCD; one pulse only.
//  2 Read: we_n=1,oe_n=0,lb_n=0,addr=0x3FFFFF
//    -> req write=0,lb=1,addr=0x3FFFFF,wdata=0; rd_active high until oe_n rises (+sync).
//  3 Glitch: we_n low for 1 clk
//    -> no req_valid; we_n and oe_n both low -> write request.
//  4 Backpressure: ready=0 for 6 cycles then 1
//    -> req_* constant throughout, exactly one accepted handshake.
//  5 Overrun: ready=0, we_n pulse, then second pulse
//    -> err_overrun=1, one request only; stays 1 until rst.
//  6 Abort: fpga_enable=0 during ISSUE -> req_valid=0 within SYNC_STAGES+1 cycles.
//    rst pulse in SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/sram_bus_frontend.sv
// SRAM bus front end: synchronises the asynchronous SRAM-style pins, filters
// short strobes and turns each qualified access into one valid/ready request.
module sram_bus_frontend #(
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpga_enable,
  input  logic              bus_ce_n,
  input  logic              bus_ce2,
  input  logic              bus_we_n,
  input  logic              bus_oe_n,
  input  logic              bus_lb_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic              req_lb,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic              rd_active,
  output logic              err_overrun
);

  localparam int PIN_W = 6 + ADDR_W + DATA_W;
  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  // Active-low pins idle high so the synced copies never show a phantom strobe.
  localparam logic [PIN_W-1:0] PIN_RST = {6'b010111, {(ADDR_W + DATA_W){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ISSUE, S_HOLD} state_t;

  logic [SYNC_STAGES-1:0][PIN_W-1:0] pin_sync_q, pin_sync_d;
  logic [PIN_W-1:0]  pin_raw;
  logic              en_s, ce_n_s, ce2_s, we_n_s, oe_n_s, lb_n_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] data_s;
  logic              sel, wr, rd;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              type_q, type_d;
  logic              gap_q, gap_d;
  logic              capture;
  logic              req_valid_q, req_valid_d;
  logic              req_write_q, req_write_d;
  logic              req_lb_q, req_lb_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              err_q, err_d;

  assign pin_raw = {fpga_enable, bus_ce_n, bus_ce2, bus_we_n, bus_oe_n, bus_lb_n,
                    bus_addr, bus_data_in};
  assign {en_s, ce_n_s, ce2_s, we_n_s, oe_n_s, lb_n_s, addr_s, data_s} =
         pin_sync_q[SYNC_STAGES-1];

  assign sel = en_s & ~ce_n_s & ce2_s;
  assign wr  = sel & ~we_n_s;
  assign rd  = sel & we_n_s & ~oe_n_s;

  // Synchroniser shift: index 0 takes the raw pins, the oldest stage feeds the logic.
  always_comb begin
    pin_sync_d = {pin_sync_q[SYNC_STAGES-2:0], pin_raw};
  end

  // Next-state, capture, handshake and overrun logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    gap_d       = gap_q;
    capture     = 1'b0;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_lb_d    = req_lb_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    err_d       = err_q;
    if (!en_s) begin
      state_d     = S_IDLE;
      cnt_d       = {CNT_W{1'b0}};
      gap_d       = 1'b0;
      req_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr | rd) begin
            type_d = wr;
            cnt_d  = CNT_W'(1);
            if (SETTLE_CYC == 32'sd1) begin
              capture = 1'b1;
            end else begin
              state_d = S_SETTLE;
            end
          end else begin
            cnt_d = {CNT_W{1'b0}};
          end
        end
        S_SETTLE: begin
          if (type_q ? wr : rd) begin
            if (cnt_q == SETTLE_LAST) begin
              capture = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ISSUE: begin
          // A strobe that vanished and came back before acceptance is a lost access.
          if (wr | rd) begin
            if (gap_q) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            gap_d = 1'b1;
          end
          if (req_ready) begin
            req_valid_d = 1'b0;
            gap_d       = 1'b0;
            state_d     = (wr | rd) ? S_HOLD : S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_HOLD: begin
          if (wr | rd) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (capture) begin
        state_d     = S_ISSUE;
        gap_d       = 1'b0;
        req_valid_d = 1'b1;
        req_write_d = type_d;
        req_lb_d    = ~lb_n_s;
        req_addr_d  = addr_s;
        req_wdata_d = type_d ? data_s : {DATA_W{1'b0}};
      end else begin
        req_write_d = req_write_q;
      end
    end
  end

  // State, synchroniser and request registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_sync_q  <= {SYNC_STAGES{PIN_RST}};
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      type_q      <= 1'b0;
      gap_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_lb_q    <= 1'b0;
      req_addr_q  <= {ADDR_W{1'b0}};
      req_wdata_q <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      pin_sync_q  <= pin_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      gap_q       <= gap_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_lb_q    <= req_lb_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      err_q       <= err_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_write   = req_write_q;
  assign req_lb      = req_lb_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign err_overrun = err_q;
  assign rd_active   = ((state_q == S_ISSUE) | (state_q == S_HOLD)) & ~req_write_q & rd;

endmodule
